// File: rtl/seq_right_shifter_pkg.sv
// Shared ALU constants: shift op codes and the sequential shifter
// state encoding, common to the left and right shifters.
package seq_right_shifter_pkg;

    localparam logic [5:0] OP_SLL = 6'b000000;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

    function automatic logic is_right_shift(input logic [5:0] op);
        return (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/seq_right_shifter_shift1_right.sv
// One-bit right shift step; SRA replicates the MSB, anything else
// fills with zero.
module shift1_right
    import seq_right_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic [5:0]       op,
    output logic [WIDTH-1:0] result
);

    logic fill;

    always_comb begin
        fill   = (op == OP_SRA) ? value[WIDTH-1] : 1'b0;
        result = {fill, value[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter: one bit per clock, result and status
// outputs all registered.
module seq_right_shifter
    import seq_right_shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [31:0]      dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    shift_state_e         state_q, state_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]           op_q, op_d;
    logic [WIDTH-1:0]     data_out_q, data_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     work_shifted;

    // Upper shift-amount bits are architecturally ignored.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^dataB[31:SHAMT_W];

    shift1_right #(
        .WIDTH (WIDTH)
    ) u_shift1 (
        .value  (work_q),
        .op     (op_q),
        .result (work_shifted)
    );

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        data_out_d = data_out_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = dataA;
                    cnt_d   = dataB[SHAMT_W-1:0];
                    op_d    = Signal;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!is_right_shift(op_q)) begin
                    data_out_d = '0;
                    state_d    = ST_DONE;
                end else if (cnt_q != '0) begin
                    work_d = work_shifted;
                    cnt_d  = cnt_q - SHAMT_W'(1);
                end else begin
                    data_out_d = work_q;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags track the next state so they line up with it.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dataOut = data_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
